// File: rtl/otter_cu_fsm.sv
// Multicycle control sequencer for the OTTER MCU: fetch, execute, memory wait, writeback, interrupt entry.
// Outputs are combinational from state and the IR opcode/funct3 fields.
module otter_cu_fsm #(
   parameter int MEM_WAIT = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       intr,
   output logic       PCWrite,
   output logic       regWrite,
   output logic       memWE2,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       reset,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Counter load value for the MEMW phase; unused when MEM_WAIT is 0.
   localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_MEMW,
      ST_WB,
      ST_INTR
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       done;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done      = 1'b0;
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      reset     = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;

      case (state_q)
         ST_INIT: begin
            reset   = 1'b1;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            memRDEN1 = 1'b1;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            case (opcode)
               OP_LOAD: begin
                  memRDEN2 = 1'b1;
                  if (MEM_WAIT == 0) begin
                     state_d = ST_WB;
                  end else begin
                     state_d = ST_MEMW;
                     cnt_d   = WAIT_INIT;
                  end
               end
               OP_STORE: begin
                  memWE2 = 1'b1;
                  if (MEM_WAIT == 0) begin
                     done = 1'b1;
                  end else begin
                     state_d = ST_MEMW;
                     cnt_d   = WAIT_INIT;
                  end
               end
               OP_BRANCH: done = 1'b1;
               OP_JAL, OP_JALR, OP_RTYPE, OP_IARITH, OP_LUI, OP_AUIPC: begin
                  regWrite = 1'b1;
                  done     = 1'b1;
               end
               OP_SYSTEM: begin
                  done = 1'b1;
                  if (funct3 == 3'b000) begin
                     mret_exec = 1'b1;
                  end else if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
                     regWrite = 1'b1;
                     csr_WE   = 1'b1;
                  end
               end
               default: done = 1'b1;
            endcase
         end
         // Only loads and stores reach MEMW; opcode is held stable by the IR.
         ST_MEMW: begin
            if (opcode == OP_LOAD) begin
               memRDEN2 = 1'b1;
            end else begin
               memWE2 = 1'b1;
            end
            if (cnt_q == 4'd0) begin
               if (opcode == OP_LOAD) begin
                  state_d = ST_WB;
               end else begin
                  done = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WB: begin
            regWrite = 1'b1;
            done     = 1'b1;
         end
         ST_INTR: begin
            int_taken = 1'b1;
            PCWrite   = 1'b1;
            state_d   = ST_FETCH;
         end
         default: state_d = ST_INIT;
      endcase

      if (done) begin
         PCWrite = 1'b1;
         state_d = intr ? ST_INTR : ST_FETCH;
      end
   end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: three instances with MEM_WAIT = 0, 2, 3 share one stimulus stream.
module tb_otter_cu_fsm;

   // Output vector: {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
   localparam logic [8:0] E_INIT  = 9'h008;
   localparam logic [8:0] E_FETCH = 9'h020;
   localparam logic [8:0] E_ALU   = 9'h180;
   localparam logic [8:0] E_LD    = 9'h010;
   localparam logic [8:0] E_WB    = 9'h180;
   localparam logic [8:0] E_ST    = 9'h040;
   localparam logic [8:0] E_STFIN = 9'h140;
   localparam logic [8:0] E_INTR  = 9'h102;
   localparam logic [8:0] E_MRET  = 9'h101;
   localparam logic [8:0] E_CSR   = 9'h184;
   localparam logic [8:0] E_PCW   = 9'h100;

   localparam logic [6:0] OP_ADD   = 7'b0110011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] OP_BOGUS = 7'b0000000;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       intr;
   wire  [8:0] o0, o2, o3;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   otter_cu_fsm #(.MEM_WAIT(0)) u0 (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .intr(intr),
      .PCWrite(o0[8]), .regWrite(o0[7]), .memWE2(o0[6]), .memRDEN1(o0[5]),
      .memRDEN2(o0[4]), .reset(o0[3]), .csr_WE(o0[2]), .int_taken(o0[1]), .mret_exec(o0[0])
   );
   otter_cu_fsm #(.MEM_WAIT(2)) u2 (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .intr(intr),
      .PCWrite(o2[8]), .regWrite(o2[7]), .memWE2(o2[6]), .memRDEN1(o2[5]),
      .memRDEN2(o2[4]), .reset(o2[3]), .csr_WE(o2[2]), .int_taken(o2[1]), .mret_exec(o2[0])
   );
   otter_cu_fsm #(.MEM_WAIT(3)) u3 (
      .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .intr(intr),
      .PCWrite(o3[8]), .regWrite(o3[7]), .memWE2(o3[6]), .memRDEN1(o3[5]),
      .memRDEN2(o3[4]), .reset(o3[3]), .csr_WE(o3[2]), .int_taken(o3[1]), .mret_exec(o3[0])
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Leaves every instance in FETCH.
   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
   endtask

   initial begin
      RST    = 1'b1;
      opcode = OP_ADD;
      funct3 = 3'b000;
      intr   = 1'b0;

      // Reset and release
      tick();
      chk("rst_cycle1_mw0", o0, E_INIT);
      tick();
      chk("rst_cycle2_mw2", o2, E_INIT);
      RST = 1'b0;
      #1;
      chk("init_after_release", o0, E_INIT);
      tick();
      chk("first_fetch", o0, E_FETCH);

      // ADD loop, period 2
      tick();
      chk("add_exec", o0, E_ALU);
      tick();
      chk("add_fetch2", o0, E_FETCH);
      tick();
      chk("add_exec2", o0, E_ALU);
      tick();
      chk("add_fetch3", o0, E_FETCH);

      // LW: MEM_WAIT=2 on u2, MEM_WAIT=0 on u0
      opcode = OP_LW;
      do_reset();
      chk("lw_fetch", o2, E_FETCH);
      tick();
      chk("lw_exec_mw2", o2, E_LD);
      chk("lw_exec_mw0", o0, E_LD);
      tick();
      chk("lw_memw1_mw2", o2, E_LD);
      chk("lw_wb_mw0", o0, E_WB);
      tick();
      chk("lw_memw2_mw2", o2, E_LD);
      chk("lw_fetch_mw0", o0, E_FETCH);
      tick();
      chk("lw_wb_mw2", o2, E_WB);
      tick();
      chk("lw_next_fetch_mw2", o2, E_FETCH);

      // SW: MEM_WAIT=2 on u2, MEM_WAIT=0 on u0
      opcode = OP_SW;
      do_reset();
      tick();
      chk("sw_exec_mw2", o2, E_ST);
      chk("sw_exec_mw0", o0, E_STFIN);
      tick();
      chk("sw_memw1_mw2", o2, E_ST);
      chk("sw_fetch_mw0", o0, E_FETCH);
      tick();
      chk("sw_memw_final_mw2", o2, E_STFIN);
      tick();
      chk("sw_next_fetch_mw2", o2, E_FETCH);

      // Interrupt raised during FETCH of ADD, held to completion
      opcode = OP_ADD;
      do_reset();
      intr = 1'b1;
      tick();
      chk("intr_add_exec", o0, E_ALU);
      tick();
      chk("intr_entry", o0, E_INTR);
      intr = 1'b0;
      tick();
      chk("intr_then_fetch", o0, E_FETCH);

      // intr pulsed only in FETCH is ignored
      intr = 1'b1;
      tick();
      intr = 1'b0;
      chk("pulse_exec", o0, E_ALU);
      tick();
      chk("pulse_no_intr", o0, E_FETCH);

      // MRET together with intr: MRET completes, then INTR
      opcode = OP_SYS;
      funct3 = 3'b000;
      intr   = 1'b1;
      tick();
      chk("mret_exec", o0, E_MRET);
      tick();
      chk("mret_then_intr", o0, E_INTR);
      tick();
      chk("intr_ignores_intr", o0, E_FETCH);
      intr = 1'b0;

      // CSR access, branch, unknown opcode
      funct3 = 3'b010;
      tick();
      chk("csrrs_exec", o0, E_CSR);
      tick();
      funct3 = 3'b100;
      tick();
      chk("sys_f3_100_nop", o0, E_PCW);
      tick();
      opcode = OP_BR;
      tick();
      chk("branch_exec", o0, E_PCW);
      tick();
      opcode = OP_BOGUS;
      tick();
      chk("bogus_nop", o0, E_PCW);
      tick();
      chk("bogus_then_fetch", o0, E_FETCH);

      // Reset mid-wait on a MEM_WAIT=3 load
      opcode = OP_LW;
      funct3 = 3'b010;
      do_reset();
      tick();
      chk("lw3_exec", o3, E_LD);
      tick();
      chk("lw3_memw1", o3, E_LD);
      RST = 1'b1;
      tick();
      chk("lw3_rst_init", o3, E_INIT);
      RST = 1'b0;
      tick();
      chk("lw3_rst_fetch", o3, E_FETCH);

      // Full MEM_WAIT=3 load after the abort
      tick();
      chk("lw3b_exec", o3, E_LD);
      tick();
      tick();
      tick();
      chk("lw3b_memw3", o3, E_LD);
      tick();
      chk("lw3b_wb", o3, E_WB);
      tick();
      chk("lw3b_fetch", o3, E_FETCH);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
